// File: rtl/alu_step_sequencer_if.sv
// Control-step bus between the hardwired step sequencer and the phase datapath.
// Handshake: Start is sampled only while the sequencer is idle; Done or Illegal then pulses for one cycle.
interface alu_step_sequencer_if #(
    parameter int NUM_REGS   = 16,
    parameter int ALU_CTRL_W = 5
);
    logic                  Start;
    logic                  Mem_ready;
    logic [31:0]           IR_q;
    logic                  PCout;
    logic                  PCin;
    logic                  IncrementPC;
    logic                  MARin;
    logic                  Read;
    logic                  MDRin;
    logic                  MDRout;
    logic                  IRin;
    logic                  Yin;
    logic                  Zin;
    logic                  ZLOout;
    logic                  ZHIout;
    logic                  LOin;
    logic                  HIin;
    logic [NUM_REGS-1:0]   Rout;
    logic [NUM_REGS-1:0]   Rin;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  Busy;
    logic                  Done;
    logic                  Illegal;
    logic                  Fault;

    modport master (
        input  Start, Mem_ready, IR_q,
        output PCout, PCin, IncrementPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
               ZLOout, ZHIout, LOin, HIin, Rout, Rin, ALUControl, Busy, Done, Illegal, Fault
    );

    modport slave (
        output Start, Mem_ready, IR_q,
        input  PCout, PCin, IncrementPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
               ZLOout, ZHIout, LOin, HIin, Rout, Rin, ALUControl, Busy, Done, Illegal, Fault
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Hardwired control-step sequencer: fetch, decode, execute and writeback strobes for one instruction.
// Every strobe is a registered decode of the state being entered, so outputs line up with the state.
module alu_step_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int ALU_CTRL_W  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    alu_step_sequencer_if.master bus,
    output logic [3:0]           dbg_state
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ILL
    } state_t;

    typedef enum logic [1:0] {C_BIN, C_WIDE, C_UNARY, C_ILL} cls_t;

    typedef struct packed {
        logic                  pcout;
        logic                  pcin;
        logic                  incpc;
        logic                  marin;
        logic                  read;
        logic                  mdrin;
        logic                  mdrout;
        logic                  irin;
        logic                  yin;
        logic                  zin;
        logic                  zloout;
        logic                  zhiout;
        logic                  loin;
        logic                  hiin;
        logic                  busy;
        logic                  done;
        logic                  illegal;
        logic [NUM_REGS-1:0]   rout;
        logic [NUM_REGS-1:0]   rin;
        logic [ALU_CTRL_W-1:0] alu;
    } ctrl_t;

    state_t        state, next_state;
    ctrl_t         ctrl_d, ctrl_q;
    logic [CW-1:0] tmo_cnt, tmo_cnt_d;
    logic          fault_q, fault_d;
    logic [16:0]   ir_lat;
    logic [16:0]   ir_src;
    logic [4:0]    op;
    logic [RW-1:0] ra, rb, rc;
    cls_t          cls;
    logic          ir_unused;

    function automatic cls_t decode(input logic [4:0] o);
        if (o >= 5'd3 && o <= 5'd14) return C_BIN;
        if (o == 5'd15 || o == 5'd16) return C_WIDE;
        if (o == 5'd17 || o == 5'd18) return C_UNARY;
        return C_ILL;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // IR is read live while in DEC and from the latched copy afterwards.
    assign ir_src    = (state == S_DEC) ? bus.IR_q[31:15] : ir_lat;
    assign ir_unused = ^bus.IR_q[14:0];
    assign op        = ir_src[16:12];
    assign ra        = ir_src[8 +: RW];
    assign rb        = ir_src[4 +: RW];
    assign rc        = ir_src[0 +: RW];
    assign cls       = decode(op);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            ctrl_q  <= '0;
            tmo_cnt <= '0;
            fault_q <= 1'b0;
            ir_lat  <= '0;
        end else begin
            state   <= next_state;
            ctrl_q  <= ctrl_d;
            tmo_cnt <= tmo_cnt_d;
            fault_q <= fault_d;
            if (state == S_DEC) ir_lat <= bus.IR_q[31:15];
        end
    end

    always_comb begin
        next_state = state;
        tmo_cnt_d  = tmo_cnt;
        fault_d    = fault_q;
        case (state)
            S_IDLE: if (bus.Start) begin
                next_state = S_T0;
                fault_d    = 1'b0;
            end
            S_T0: begin
                next_state = S_T1;
                tmo_cnt_d  = '0;
            end
            S_T1: begin
                if (bus.Mem_ready) begin
                    next_state = S_T2;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state = S_IDLE;
                    fault_d    = 1'b1;
                end else begin
                    tmo_cnt_d = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
                end
            end
            S_T2:   next_state = S_DEC;
            S_DEC: begin
                case (cls)
                    C_BIN, C_WIDE: next_state = S_T3;
                    C_UNARY:       next_state = S_T4;
                    default:       next_state = S_ILL;
                endcase
            end
            S_T3:   next_state = S_T4;
            S_T4:   next_state = S_T5;
            S_T5:   next_state = (cls == C_WIDE) ? S_T6 : S_DONE;
            S_T6:   next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered and registered alongside it.
    always_comb begin
        ctrl_d = '0;
        case (next_state)
            S_T0: begin
                ctrl_d.pcout = 1'b1;
                ctrl_d.marin = 1'b1;
                ctrl_d.zin   = 1'b1;
                ctrl_d.incpc = 1'b1;
                ctrl_d.busy  = 1'b1;
            end
            S_T1: begin
                ctrl_d.zloout = 1'b1;
                ctrl_d.pcin   = (state != S_T1);
                ctrl_d.read   = 1'b1;
                ctrl_d.mdrin  = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdrout = 1'b1;
                ctrl_d.irin   = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            S_DEC: ctrl_d.busy = 1'b1;
            S_T3: begin
                ctrl_d.rout = onehot(rb);
                ctrl_d.yin  = 1'b1;
                ctrl_d.busy = 1'b1;
            end
            S_T4: begin
                ctrl_d.rout = (cls == C_UNARY) ? onehot(rb) : onehot(rc);
                ctrl_d.zin  = 1'b1;
                ctrl_d.alu  = ALU_CTRL_W'(op);
                ctrl_d.busy = 1'b1;
            end
            S_T5: begin
                ctrl_d.zloout = 1'b1;
                ctrl_d.busy   = 1'b1;
                if (cls == C_WIDE) ctrl_d.loin = 1'b1;
                else               ctrl_d.rin  = onehot(ra);
            end
            S_T6: begin
                ctrl_d.zhiout = 1'b1;
                ctrl_d.hiin   = 1'b1;
                ctrl_d.busy   = 1'b1;
            end
            S_DONE: ctrl_d.done    = 1'b1;
            S_ILL:  ctrl_d.illegal = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    assign bus.PCout       = ctrl_q.pcout;
    assign bus.PCin        = ctrl_q.pcin;
    assign bus.IncrementPC = ctrl_q.incpc;
    assign bus.MARin       = ctrl_q.marin;
    assign bus.Read        = ctrl_q.read;
    assign bus.MDRin       = ctrl_q.mdrin;
    assign bus.MDRout      = ctrl_q.mdrout;
    assign bus.IRin        = ctrl_q.irin;
    assign bus.Yin         = ctrl_q.yin;
    assign bus.Zin         = ctrl_q.zin;
    assign bus.ZLOout      = ctrl_q.zloout;
    assign bus.ZHIout      = ctrl_q.zhiout;
    assign bus.LOin        = ctrl_q.loin;
    assign bus.HIin        = ctrl_q.hiin;
    assign bus.Rout        = ctrl_q.rout;
    assign bus.Rin         = ctrl_q.rin;
    assign bus.ALUControl  = ctrl_q.alu;
    assign bus.Busy        = ctrl_q.busy;
    assign bus.Done        = ctrl_q.done;
    assign bus.Illegal     = ctrl_q.illegal;
    assign bus.Fault       = fault_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: per-cycle expected strobe words are queued when an
// instruction is launched and popped/compared cycle by cycle; latency and abort cases are checked directly.
`timescale 1ns/1ps
module tb_alu_step_sequencer;
    localparam int NUM_REGS    = 16;
    localparam int ALU_CTRL_W  = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int W           = 64;

    localparam logic [17:0] B_PCOUT  = 18'h20000;
    localparam logic [17:0] B_PCIN   = 18'h10000;
    localparam logic [17:0] B_INCPC  = 18'h08000;
    localparam logic [17:0] B_MARIN  = 18'h04000;
    localparam logic [17:0] B_READ   = 18'h02000;
    localparam logic [17:0] B_MDRIN  = 18'h01000;
    localparam logic [17:0] B_MDROUT = 18'h00800;
    localparam logic [17:0] B_IRIN   = 18'h00400;
    localparam logic [17:0] B_YIN    = 18'h00200;
    localparam logic [17:0] B_ZIN    = 18'h00100;
    localparam logic [17:0] B_ZLO    = 18'h00080;
    localparam logic [17:0] B_ZHI    = 18'h00040;
    localparam logic [17:0] B_LOIN   = 18'h00020;
    localparam logic [17:0] B_HIIN   = 18'h00010;
    localparam logic [17:0] B_BUSY   = 18'h00008;
    localparam logic [17:0] B_DONE   = 18'h00004;
    localparam logic [17:0] B_ILL    = 18'h00002;
    localparam logic [17:0] B_FAULT  = 18'h00001;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic [3:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    alu_step_sequencer_if #(.NUM_REGS(NUM_REGS), .ALU_CTRL_W(ALU_CTRL_W)) bus();

    alu_step_sequencer #(
        .NUM_REGS(NUM_REGS), .ALU_CTRL_W(ALU_CTRL_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .bus(bus), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [17:0] s, input logic [15:0] ro,
                                        input logic [15:0] ri, input logic [4:0] alu);
        return {9'b0, s, ro, ri, alu};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic logic [W-1:0] obs_word();
        return mk({bus.PCout, bus.PCin, bus.IncrementPC, bus.MARin, bus.Read, bus.MDRin,
                   bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.LOin,
                   bus.HIin, bus.Busy, bus.Done, bus.Illegal, bus.Fault},
                  bus.Rout, bus.Rin, bus.ALUControl);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: one expected output word per cycle from T0 to the idle cycle after the instruction.
    task automatic push_expect(input logic [31:0] ir, input int waits, input bit tmo);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit bin, wide, unary;
        int n1;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        bin   = (op >= 5'd3 && op <= 5'd14);
        wide  = (op == 5'd15 || op == 5'd16);
        unary = (op == 5'd17 || op == 5'd18);
        exp_q.push_back(mk(B_PCOUT | B_MARIN | B_ZIN | B_INCPC | B_BUSY, 16'h0, 16'h0, 5'h0));
        n1 = tmo ? MEM_TIMEOUT : waits + 1;
        for (int i = 0; i < n1; i++)
            exp_q.push_back(mk(B_ZLO | B_READ | B_MDRIN | B_BUSY | ((i == 0) ? B_PCIN : 18'h0),
                               16'h0, 16'h0, 5'h0));
        if (tmo) begin
            exp_q.push_back(mk(B_FAULT, 16'h0, 16'h0, 5'h0));
            return;
        end
        exp_q.push_back(mk(B_MDROUT | B_IRIN | B_BUSY, 16'h0, 16'h0, 5'h0));
        exp_q.push_back(mk(B_BUSY, 16'h0, 16'h0, 5'h0));
        if (!(bin || wide || unary)) begin
            exp_q.push_back(mk(B_ILL, 16'h0, 16'h0, 5'h0));
            exp_q.push_back(mk(18'h0, 16'h0, 16'h0, 5'h0));
            return;
        end
        if (!unary) exp_q.push_back(mk(B_YIN | B_BUSY, oh(rb), 16'h0, 5'h0));
        exp_q.push_back(mk(B_ZIN | B_BUSY, unary ? oh(rb) : oh(rc), 16'h0, op));
        if (wide) begin
            exp_q.push_back(mk(B_ZLO | B_LOIN | B_BUSY, 16'h0, 16'h0, 5'h0));
            exp_q.push_back(mk(B_ZHI | B_HIIN | B_BUSY, 16'h0, 16'h0, 5'h0));
        end else begin
            exp_q.push_back(mk(B_ZLO | B_BUSY, 16'h0, oh(ra), 5'h0));
        end
        exp_q.push_back(mk(B_DONE, 16'h0, 16'h0, 5'h0));
        exp_q.push_back(mk(18'h0, 16'h0, 16'h0, 5'h0));
    endtask

    // Driver: launch one instruction and compare every cycle until the sequencer is idle again.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int waits,
                             input bit tmo, input int exp_done);
        int n;
        int done_cycle;
        push_expect(ir, waits, tmo);
        n = exp_q.size();
        @(negedge Clock);
        bus.IR_q      = ir;
        bus.Start     = 1'b1;
        bus.Mem_ready = 1'b1;
        done_cycle    = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge Clock);
            if (bus.Done && done_cycle == 0) done_cycle = c;
            check($sformatf("%s_cyc%0d", tag, c), obs_word(), exp_q.pop_front());
            bus.Start     = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.Mem_ready = !(c >= 2 && (tmo || c < 2 + waits));
        end
        check({tag, "_done_cycle"}, W'(done_cycle), W'(exp_done));
    endtask

    // Only one source may drive the shared bus in any cycle.
    always @(negedge Clock) begin
        checks++;
        assert ($countones({bus.Rout, bus.PCout, bus.MDRout, bus.ZLOout, bus.ZHIout}) <= 1) else begin
            errors++;
            $error("FAIL bus_exclusive observed rout=%h pc=%b mdr=%b zlo=%b zhi=%b expected at most one",
                   bus.Rout, bus.PCout, bus.MDRout, bus.ZLOout, bus.ZHIout);
        end
    end

    initial begin
        logic [4:0] op;
        int waits;
        int lat;
        bus.Start     = 1'b0;
        bus.Mem_ready = 1'b0;
        bus.IR_q      = 32'h0;

        // Reset state
        repeat (3) @(negedge Clock);
        check("reset_outputs", obs_word(), W'(0));
        check("reset_state", W'(dbg_state), W'(0));
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_reset_outputs", obs_word(), W'(0));

        run_instr("bin_add", 32'h28918000, 0, 1'b0, 8);
        run_instr("neg", mk_ir(5'd17, 4'd4, 4'd5, 4'd9), 0, 1'b0, 7);
        run_instr("mul", mk_ir(5'd15, 4'd6, 4'd7, 4'd8), 0, 1'b0, 9);
        run_instr("bin_wait3", mk_ir(5'd3, 4'd15, 4'd0, 4'd14), 3, 1'b0, 11);

        // Memory never ready: Fault, back to idle, cleared by the next Start
        run_instr("timeout", mk_ir(5'd9, 4'd1, 4'd1, 4'd1), 0, 1'b1, 0);
        @(negedge Clock);
        check("fault_sticky", W'(bus.Fault), W'(1));
        check("fault_idle_state", W'(dbg_state), W'(0));
        run_instr("div_after_fault", mk_ir(5'd16, 4'd2, 4'd10, 4'd11), 1, 1'b0, 10);

        run_instr("illegal_31", mk_ir(5'd31, 4'd3, 4'd4, 4'd5), 0, 1'b0, 0);
        run_instr("illegal_0", mk_ir(5'd0, 4'd3, 4'd4, 4'd5), 0, 1'b0, 0);
        run_instr("not", mk_ir(5'd18, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                               4'($urandom_range(0, 15))), 0, 1'b0, 7);
        run_instr("bin_top", mk_ir(5'd14, 4'd0, 4'd15, 4'd0), 2, 1'b0, 10);

        for (int i = 0; i < 4; i++) begin
            op    = 5'($urandom_range(3, 18));
            waits = $urandom_range(0, 2);
            lat   = (op <= 5'd14) ? 8 : (op <= 5'd16) ? 9 : 7;
            run_instr($sformatf("rand%0d", i),
                      mk_ir(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15))), waits, 1'b0, lat + waits);
        end

        // Reset asserted mid-instruction (T4) aborts with no Done
        @(negedge Clock);
        bus.IR_q      = mk_ir(5'd7, 4'd2, 4'd3, 4'd4);
        bus.Start     = 1'b1;
        bus.Mem_ready = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (5) @(negedge Clock);
        check("abort_t4_state", W'(dbg_state), W'(6));
        check("abort_t4_word", obs_word(), mk(B_ZIN | B_BUSY, 16'h0010, 16'h0, 5'd7));
        #2 Resetn = 1'b0;
        #1;
        check("abort_async_outputs", obs_word(), W'(0));
        check("abort_async_state", W'(dbg_state), W'(0));
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            check("abort_held_outputs", obs_word(), W'(0));
        end
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("abort_after_release", obs_word(), W'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
